// File: rtl/dmem_arbiter.sv
// dmem_arbiter: one data-memory access per cycle, host first, with a bounded-wait
// override for the pipeline; memory ports registered, reads returned with owner tags.
module dmem_arbiter #(
  parameter int unsigned PIPE_WAIT_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_to_dmem,
  input  logic        read_req_dmem,
  input  logic [7:0]  addr_dmem_host,
  input  logic [31:0] data_dmem_host,
  input  logic        pipeline_we,
  input  logic        pipeline_re,
  input  logic [31:0] pipeline_addr,
  input  logic [31:0] pipeline_data,
  output logic        pipeline_stall,
  output logic [63:0] pipeline_rdata,
  output logic        pipeline_rvalid,
  output logic [63:0] host_rdata,
  output logic        host_ack,
  output logic        host_busy,
  output logic        host_err,
  output logic [15:0] stall_cnt,
  output logic [7:0]  mem_addra,
  output logic [63:0] mem_dina,
  output logic        mem_wea,
  output logic [7:0]  mem_addrb,
  input  logic [63:0] mem_doutb
);

  localparam logic [3:0] WAIT_MAX = 4'(PIPE_WAIT_MAX);
  localparam logic OWN_HOST = 1'b0;
  localparam logic OWN_PIPE = 1'b1;

  logic        hold_v_q, hold_v_d, hold_we_q, hold_we_d;
  logic [7:0]  hold_addr_q, hold_addr_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        s1_v_q, s1_v_d, s1_own_q, s1_own_d, s1_rd_q, s1_rd_d;
  logic        s2_v_q, s2_v_d, s2_own_q, s2_own_d, s2_rd_q, s2_rd_d;
  logic        err_q, err_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [63:0] mem_din_q, mem_din_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] host_rdata_q, host_rdata_d, pipe_rdata_q, pipe_rdata_d;
  logic        host_ack_q, host_ack_d, pipe_rvalid_q, pipe_rvalid_d;

  logic        busy, pulse_any, pulse_ok, pipe_req, force_pipe;
  logic        host_grant, pipe_grant, stall;
  logic        g_we;
  logic [7:0]  g_addr;
  logic [31:0] g_data;
  logic        addr_hi_unused;

  assign addr_hi_unused = ^pipeline_addr[31:8];

  always_comb begin
    busy = hold_v_q | (s1_v_q & s1_rd_q & (s1_own_q == OWN_HOST))
                    | (s2_v_q & s2_rd_q & (s2_own_q == OWN_HOST));
    pulse_any  = write_to_dmem | read_req_dmem;
    pulse_ok   = pulse_any & ~busy;
    pipe_req   = pipeline_we | pipeline_re;
    force_pipe = pipe_req & (wait_cnt_q >= WAIT_MAX);
    host_grant = ~force_pipe & (hold_v_q | pulse_ok);
    pipe_grant = pipe_req & ~host_grant;
    stall      = pipe_req & ~pipe_grant;

    g_we   = pipeline_we;
    g_addr = pipeline_addr[7:0];
    g_data = pipeline_data;
    if (host_grant && hold_v_q) begin
      g_we   = hold_we_q;
      g_addr = hold_addr_q;
      g_data = hold_data_q;
    end else if (host_grant) begin
      g_we   = write_to_dmem;
      g_addr = addr_dmem_host;
      g_data = data_dmem_host;
    end

    hold_v_d    = hold_v_q & ~host_grant;
    hold_we_d   = hold_we_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    // Pipeline overrides the host this cycle: park the live pulse instead of losing it.
    if (force_pipe && pulse_ok) begin
      hold_v_d    = 1'b1;
      hold_we_d   = write_to_dmem;
      hold_addr_d = addr_dmem_host;
      hold_data_d = data_dmem_host;
    end

    err_d = err_q | (pulse_any & busy) | (write_to_dmem & read_req_dmem);

    wait_cnt_d  = stall ? ((wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1) : 4'd0;
    stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;

    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    if (host_grant || pipe_grant) begin
      mem_addr_d = g_addr;
      mem_we_d   = g_we;
      if (g_we) mem_din_d = {32'b0, g_data};
    end

    s1_v_d   = (host_grant | pipe_grant) & ~g_we;
    s1_own_d = pipe_grant ? OWN_PIPE : OWN_HOST;
    s1_rd_d  = ~g_we;
    s2_v_d   = s1_v_q;
    s2_own_d = s1_own_q;
    s2_rd_d  = s1_rd_q;

    host_ack_d    = (host_grant & g_we) | (s2_v_q & s2_rd_q & (s2_own_q == OWN_HOST));
    pipe_rvalid_d = s2_v_q & s2_rd_q & (s2_own_q == OWN_PIPE);
    host_rdata_d  = (s2_v_q & s2_rd_q & (s2_own_q == OWN_HOST)) ? mem_doutb : host_rdata_q;
    pipe_rdata_d  = pipe_rvalid_d ? mem_doutb : pipe_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v_q <= 1'b0; hold_we_q <= 1'b0; hold_addr_q <= '0; hold_data_q <= '0;
      wait_cnt_q <= '0; stall_cnt_q <= '0; err_q <= 1'b0;
      s1_v_q <= 1'b0; s1_own_q <= 1'b0; s1_rd_q <= 1'b0;
      s2_v_q <= 1'b0; s2_own_q <= 1'b0; s2_rd_q <= 1'b0;
      mem_addr_q <= '0; mem_din_q <= '0; mem_we_q <= 1'b0;
      host_rdata_q <= '0; pipe_rdata_q <= '0; host_ack_q <= 1'b0; pipe_rvalid_q <= 1'b0;
    end else begin
      hold_v_q <= hold_v_d; hold_we_q <= hold_we_d;
      hold_addr_q <= hold_addr_d; hold_data_q <= hold_data_d;
      wait_cnt_q <= wait_cnt_d; stall_cnt_q <= stall_cnt_d; err_q <= err_d;
      s1_v_q <= s1_v_d; s1_own_q <= s1_own_d; s1_rd_q <= s1_rd_d;
      s2_v_q <= s2_v_d; s2_own_q <= s2_own_d; s2_rd_q <= s2_rd_d;
      mem_addr_q <= mem_addr_d; mem_din_q <= mem_din_d; mem_we_q <= mem_we_d;
      host_rdata_q <= host_rdata_d; pipe_rdata_q <= pipe_rdata_d;
      host_ack_q <= host_ack_d; pipe_rvalid_q <= pipe_rvalid_d;
    end
  end

  assign pipeline_stall  = stall & ~reset;
  assign pipeline_rdata  = pipe_rdata_q;
  assign pipeline_rvalid = pipe_rvalid_q;
  assign host_rdata      = host_rdata_q;
  assign host_ack        = host_ack_q;
  assign host_busy       = busy;
  assign host_err        = err_q;
  assign stall_cnt       = stall_cnt_q;
  assign mem_addra       = mem_addr_q;
  assign mem_addrb       = mem_addr_q;
  assign mem_dina        = mem_din_q;
  assign mem_wea         = mem_we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed cycle table plus hand sequences for dmem_arbiter, with a behavioural
// 256 x 64 memory attached to the ports.
module tb_dmem_arbiter;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [63:0] Z = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_to_dmem, read_req_dmem;
  logic [7:0]  addr_dmem_host;
  logic [31:0] data_dmem_host;
  logic        pipeline_we, pipeline_re;
  logic [31:0] pipeline_addr, pipeline_data;
  logic        pipeline_stall, pipeline_rvalid, host_ack, host_busy, host_err, mem_wea;
  logic [63:0] pipeline_rdata, host_rdata, mem_dina, mem_doutb;
  logic [15:0] stall_cnt;
  logic [7:0]  mem_addra, mem_addrb;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.PIPE_WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .write_to_dmem(write_to_dmem), .read_req_dmem(read_req_dmem),
    .addr_dmem_host(addr_dmem_host), .data_dmem_host(data_dmem_host),
    .pipeline_we(pipeline_we), .pipeline_re(pipeline_re),
    .pipeline_addr(pipeline_addr), .pipeline_data(pipeline_data),
    .pipeline_stall(pipeline_stall), .pipeline_rdata(pipeline_rdata),
    .pipeline_rvalid(pipeline_rvalid), .host_rdata(host_rdata),
    .host_ack(host_ack), .host_busy(host_busy), .host_err(host_err),
    .stall_cnt(stall_cnt), .mem_addra(mem_addra), .mem_dina(mem_dina),
    .mem_wea(mem_wea), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
  );

  logic [63:0] mem [256];
  always @(posedge clk) begin
    if (mem_wea) mem[mem_addra] <= mem_dina;
    mem_doutb <= mem[mem_addrb];
  end

  typedef struct {
    logic wr; logic rd; logic [7:0] ha; logic [31:0] hd;
    logic pwe; logic pre; logic [31:0] pa; logic [31:0] pd;
    logic e_stall; logic e_wea; logic [7:0] e_addr; logic [63:0] e_dina;
    logic e_ack; logic e_busy; logic e_err; logic e_rv; logic [15:0] e_scnt;
    logic c_hr; logic [63:0] e_hr; logic c_pr; logic [63:0] e_pr;
  } vec_t;

  vec_t v [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [7:0] ha, input logic [31:0] hd,
                       input logic pwe, input logic pre, input logic [31:0] pa, input logic [31:0] pd);
    write_to_dmem = wr; read_req_dmem = rd; addr_dmem_host = ha; data_dmem_host = hd;
    pipeline_we = pwe; pipeline_re = pre; pipeline_addr = pa; pipeline_data = pd;
  endtask

  task automatic idle();
    drive(F, F, 8'h0, 32'h0, F, F, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    reset = 1'b1;
    idle();

    // host write 0x12 then read back
    v.push_back('{T,F,8'h12,32'hDEADBEEF, F,F,32'h0,32'h0, F,F,8'h00,Z, F,F,F,F,16'd0, F,Z,F,Z});
    v.push_back('{F,T,8'h12,32'h0, F,F,32'h0,32'h0, F,T,8'h12,64'h00000000DEADBEEF, T,F,F,F,16'd0, F,Z,F,Z});
    v.push_back('{F,F,8'h00,32'h0, F,F,32'h0,32'h0, F,F,8'h12,Z, F,T,F,F,16'd0, F,Z,F,Z});
    v.push_back('{F,F,8'h00,32'h0, F,F,32'h0,32'h0, F,F,8'h12,Z, F,T,F,F,16'd0, F,Z,F,Z});
    v.push_back('{F,F,8'h00,32'h0, F,F,32'h0,32'h0, F,F,8'h12,Z, T,F,F,F,16'd0, T,64'h00000000DEADBEEF,F,Z});
    // pipeline store 0x05, then two loads (high address bits ignored)
    v.push_back('{F,F,8'h00,32'h0, T,F,32'h00000005,32'hCAFE0005, F,F,8'h12,Z, F,F,F,F,16'd0, F,Z,F,Z});
    v.push_back('{F,F,8'h00,32'h0, F,T,32'hFFFFFF05,32'h0, F,T,8'h05,64'h00000000CAFE0005, F,F,F,F,16'd0, F,Z,F,Z});
    v.push_back('{F,F,8'h00,32'h0, F,T,32'h00000005,32'h0, F,F,8'h05,Z, F,F,F,F,16'd0, F,Z,F,Z});
    v.push_back('{F,F,8'h00,32'h0, F,F,32'h0,32'h0, F,F,8'h05,Z, F,F,F,F,16'd0, F,Z,F,Z});
    v.push_back('{F,F,8'h00,32'h0, F,F,32'h0,32'h0, F,F,8'h05,Z, F,F,F,T,16'd0, F,Z,T,64'h00000000CAFE0005});
    v.push_back('{F,F,8'h00,32'h0, F,F,32'h0,32'h0, F,F,8'h05,Z, F,F,F,T,16'd0, F,Z,T,64'h00000000CAFE0005});
    v.push_back('{F,F,8'h00,32'h0, F,F,32'h0,32'h0, F,F,8'h05,Z, F,F,F,F,16'd0, F,Z,F,Z});
    // host writes every cycle against a held pipeline store: override on the 5th cycle
    v.push_back('{T,F,8'h20,32'h100, T,F,32'h30,32'hAAAA, T,F,8'h05,Z, F,F,F,F,16'd0, F,Z,F,Z});
    v.push_back('{T,F,8'h21,32'h101, T,F,32'h30,32'hAAAA, T,T,8'h20,64'h100, T,F,F,F,16'd1, F,Z,F,Z});
    v.push_back('{T,F,8'h22,32'h102, T,F,32'h30,32'hAAAA, T,T,8'h21,64'h101, T,F,F,F,16'd2, F,Z,F,Z});
    v.push_back('{T,F,8'h23,32'h103, T,F,32'h30,32'hAAAA, T,T,8'h22,64'h102, T,F,F,F,16'd3, F,Z,F,Z});
    v.push_back('{T,F,8'h24,32'h104, T,F,32'h30,32'hAAAA, F,T,8'h23,64'h103, T,F,F,F,16'd4, F,Z,F,Z});
    v.push_back('{F,F,8'h00,32'h0, F,F,32'h0,32'h0, F,T,8'h30,64'hAAAA, F,T,F,F,16'd4, F,Z,F,Z});
    v.push_back('{F,F,8'h00,32'h0, F,F,32'h0,32'h0, F,T,8'h24,64'h104, T,F,F,F,16'd4, F,Z,F,Z});
    // read, dropped pulse in N+1, accepted pulse in N+3
    v.push_back('{F,T,8'h12,32'h0, F,F,32'h0,32'h0, F,F,8'h24,Z, F,F,F,F,16'd4, F,Z,F,Z});
    v.push_back('{F,T,8'h24,32'h0, F,F,32'h0,32'h0, F,F,8'h12,Z, F,T,F,F,16'd4, F,Z,F,Z});
    v.push_back('{F,F,8'h00,32'h0, F,F,32'h0,32'h0, F,F,8'h12,Z, F,T,T,F,16'd4, F,Z,F,Z});
    v.push_back('{F,T,8'h24,32'h0, F,F,32'h0,32'h0, F,F,8'h12,Z, T,F,T,F,16'd4, T,64'h00000000DEADBEEF,F,Z});
    v.push_back('{F,F,8'h00,32'h0, F,F,32'h0,32'h0, F,F,8'h24,Z, F,T,T,F,16'd4, F,Z,F,Z});
    v.push_back('{F,F,8'h00,32'h0, F,F,32'h0,32'h0, F,F,8'h24,Z, F,T,T,F,16'd4, F,Z,F,Z});
    v.push_back('{F,F,8'h00,32'h0, F,F,32'h0,32'h0, F,F,8'h24,Z, T,F,T,F,16'd4, T,64'h104,F,Z});

    repeat (2) @(negedge clk);
    chk("rst wea", {63'b0, mem_wea}, 64'd0);
    chk("rst addra", {56'b0, mem_addra}, 64'd0);
    chk("rst ack", {63'b0, host_ack}, 64'd0);
    chk("rst busy", {63'b0, host_busy}, 64'd0);
    chk("rst err", {63'b0, host_err}, 64'd0);
    chk("rst rvalid", {63'b0, pipeline_rvalid}, 64'd0);
    reset = 1'b0;

    foreach (v[i]) begin
      drive(v[i].wr, v[i].rd, v[i].ha, v[i].hd, v[i].pwe, v[i].pre, v[i].pa, v[i].pd);
      #1;
      chk($sformatf("row%0d stall", i), {63'b0, pipeline_stall}, {63'b0, v[i].e_stall});
      chk($sformatf("row%0d wea", i), {63'b0, mem_wea}, {63'b0, v[i].e_wea});
      chk($sformatf("row%0d addra", i), {56'b0, mem_addra}, {56'b0, v[i].e_addr});
      chk($sformatf("row%0d addrb", i), {56'b0, mem_addrb}, {56'b0, v[i].e_addr});
      if (v[i].e_wea) chk($sformatf("row%0d dina", i), mem_dina, v[i].e_dina);
      chk($sformatf("row%0d host_ack", i), {63'b0, host_ack}, {63'b0, v[i].e_ack});
      chk($sformatf("row%0d host_busy", i), {63'b0, host_busy}, {63'b0, v[i].e_busy});
      chk($sformatf("row%0d host_err", i), {63'b0, host_err}, {63'b0, v[i].e_err});
      chk($sformatf("row%0d rvalid", i), {63'b0, pipeline_rvalid}, {63'b0, v[i].e_rv});
      chk($sformatf("row%0d stall_cnt", i), {48'b0, stall_cnt}, {48'b0, v[i].e_scnt});
      if (v[i].c_hr) chk($sformatf("row%0d host_rdata", i), host_rdata, v[i].e_hr);
      if (v[i].c_pr) chk($sformatf("row%0d pipe_rdata", i), pipeline_rdata, v[i].e_pr);
      @(negedge clk);
    end

    // simultaneous write+read pulses after reset
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("A err cleared", {63'b0, host_err}, 64'd0);
    chk("A stall_cnt cleared", {48'b0, stall_cnt}, 64'd0);
    reset = 1'b0;
    drive(T, T, 8'h40, 32'h55, F, F, 32'h0, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("A wea", {63'b0, mem_wea}, 64'd1);
    chk("A addra", {56'b0, mem_addra}, 64'h40);
    chk("A dina", mem_dina, 64'h55);
    chk("A ack", {63'b0, host_ack}, 64'd1);
    chk("A err", {63'b0, host_err}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("A no ack %0d", k), {63'b0, host_ack}, 64'd0);
      chk($sformatf("A not busy %0d", k), {63'b0, host_busy}, 64'd0);
    end
    chk("A err sticky", {63'b0, host_err}, 64'd1);

    // host read, then reset in N+1 discards it
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(F, T, 8'h40, 32'h0, F, F, 32'h0, 32'h0);
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    chk("B busy before reset", {63'b0, host_busy}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("B wea", {63'b0, mem_wea}, 64'd0);
    chk("B addra", {56'b0, mem_addra}, 64'd0);
    chk("B addrb", {56'b0, mem_addrb}, 64'd0);
    chk("B dina", mem_dina, 64'd0);
    chk("B ack", {63'b0, host_ack}, 64'd0);
    chk("B busy", {63'b0, host_busy}, 64'd0);
    chk("B err", {63'b0, host_err}, 64'd0);
    chk("B host_rdata", host_rdata, 64'd0);
    chk("B pipe_rdata", pipeline_rdata, 64'd0);
    chk("B stall_cnt", {48'b0, stall_cnt}, 64'd0);
    @(negedge clk);
    #1;
    chk("B no ack N+3", {63'b0, host_ack}, 64'd0);
    @(negedge clk);
    #1;
    chk("B no ack N+4", {63'b0, host_ack}, 64'd0);
    chk("B busy N+4", {63'b0, host_busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
